// File: rtl/node_relax_scheduler_if.sv
// Evaluator link for the relaxation scheduler: device requests out, device currents back.
// Latency: none, plain wires; responses may return any number of cycles after their request.
// Backpressure: req_ready stalls requests; responses cannot be stalled.
// Ports: req_valid/req_ready/req_idx   device evaluation request (master drives valid/idx)
//        rsp_valid/rsp_na/rsp_nb/rsp_nb_en/rsp_i   device current result (slave drives)
interface node_relax_scheduler_if #(
  parameter int NN = 64,
  parameter int NT = 128,
  parameter int W  = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic [$clog2(NT)-1:0]   req_idx;
  logic                    rsp_valid;
  logic [$clog2(NN)-1:0]   rsp_na;
  logic [$clog2(NN)-1:0]   rsp_nb;
  logic                    rsp_nb_en;
  logic signed [W-1:0]     rsp_i;

  modport master (
    output req_valid, req_idx,
    input  req_ready, rsp_valid, rsp_na, rsp_nb, rsp_nb_en, rsp_i
  );

  modport slave (
    input  req_valid, req_idx,
    output req_ready, rsp_valid, rsp_na, rsp_nb, rsp_nb_en, rsp_i
  );
endinterface

// File: rtl/node_relax_scheduler.sv
// Iterative node-voltage relaxation: sweeps a shared device evaluator, accumulates currents, updates voltages.
// Latency: per sweep 1 (clear) + NT issue + drain + NN update + 1 check; done pulses one cycle after the last check.
// Backpressure: requests stall on req_ready and when MAX_OUT are unanswered; responses are always accepted.
// Ports: clk/rst_n; start/busy/done/converged/iter_count run control; vwr_* host write (idle only);
//        vrd_* two combinational voltage read ports; ev evaluator link (master side).
module node_relax_scheduler #(
  parameter int                  W        = 16,
  parameter int                  NN       = 64,
  parameter int                  NT       = 128,
  parameter int                  AE       = 4,
  parameter logic signed [W-1:0] V_HI     = 16'sh3FFF,
  parameter logic signed [W-1:0] V_LO     = -16'sh4000,
  parameter int                  TOL      = 4,
  parameter int                  MAX_ITER = 64,
  parameter int                  MAX_OUT  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          converged,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count,
  input  logic                          vwr_en,
  input  logic [$clog2(NN)-1:0]         vwr_addr,
  input  logic [W-1:0]                  vwr_data,
  input  logic [$clog2(NN)-1:0]         vrd_addr_a,
  output logic [W-1:0]                  vrd_data_a,
  input  logic [$clog2(NN)-1:0]         vrd_addr_b,
  output logic [W-1:0]                  vrd_data_b,
  node_relax_scheduler_if.master        ev
);
  localparam int AW   = $clog2(NN);
  localparam int IW   = $clog2(NT);
  localparam int CW   = $clog2(MAX_ITER+1);
  localparam int OW   = $clog2(MAX_OUT+1);
  localparam int ACCW = W + AE;
  localparam int SW   = ACCW + 1;

  localparam logic [OW-1:0]          OUT_FULL = OW'(MAX_OUT);
  localparam logic [IW-1:0]          IDX_LAST = IW'(NT-1);
  localparam logic [AW-1:0]          NODE_LAST = AW'(NN-1);
  localparam logic [CW-1:0]          ITER_LIM = CW'(MAX_ITER);
  localparam logic [ACCW-1:0]        TOL_V    = ACCW'(TOL);
  localparam logic [ACCW-1:0]        ACC_MIN  = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic [ACCW-1:0]        ACC_MAXP = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [SW-1:0]   HI_X     = $signed({{(AE+1){V_HI[W-1]}}, V_HI});
  localparam logic signed [SW-1:0]   LO_X     = $signed({{(AE+1){V_LO[W-1]}}, V_LO});

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SWEEP, S_DRAIN, S_UPDATE, S_CHECK, S_FINISH} state_t;

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d, done_q, done_d, conv_q, conv_d;
  logic [CW-1:0]          iter_q, iter_d;
  logic                   req_valid_q, req_valid_d;
  logic [IW-1:0]          req_idx_q, req_idx_d;
  logic [OW-1:0]          outst_q, outst_d;
  logic [AW-1:0]          upd_idx_q, upd_idx_d;
  logic [ACCW-1:0]        max_abs_q, max_abs_d;
  logic                   err_q, err_d;
  logic signed [W-1:0]    v_q [NN];
  logic signed [W-1:0]    v_d [NN];
  logic signed [ACCW-1:0] acc_q [NN];
  logic signed [ACCW-1:0] acc_d [NN];

  logic                   hs, rsp_take;
  logic signed [ACCW-1:0] rsp_ext, upd_acc;
  logic signed [W-1:0]    upd_v;
  logic signed [SW-1:0]   sum;
  logic [ACCW-1:0]        acc_abs;

  assign busy         = busy_q;
  assign done         = done_q;
  assign converged    = conv_q;
  assign iter_count   = iter_q;
  assign ev.req_valid = req_valid_q;
  assign ev.req_idx   = req_idx_q;
  assign vrd_data_a   = v_q[vrd_addr_a];
  assign vrd_data_b   = v_q[vrd_addr_b];

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    conv_d    = conv_q;
    iter_d    = iter_q;
    req_idx_d = req_idx_q;
    upd_idx_d = upd_idx_q;
    max_abs_d = max_abs_q;
    v_d       = v_q;
    acc_d     = acc_q;

    hs       = req_valid_q && ev.req_ready;
    // A response with nothing outstanding is stray (e.g. issued before a reset) and is dropped.
    rsp_take = ev.rsp_valid && (outst_q != '0);
    err_d    = err_q | (ev.rsp_valid && (outst_q == '0));
    outst_d  = outst_q + OW'(hs) - OW'(rsp_take);

    // Second write reads acc_d so na==nb with nb_en cancels exactly.
    rsp_ext = {{AE{ev.rsp_i[W-1]}}, ev.rsp_i};
    if (rsp_take) begin
      acc_d[ev.rsp_na] = acc_q[ev.rsp_na] + rsp_ext;
      if (ev.rsp_nb_en) acc_d[ev.rsp_nb] = acc_d[ev.rsp_nb] - rsp_ext;
    end

    // Update datapath: one extra bit over the accumulator so the clamp sees the true sum.
    upd_acc = acc_q[upd_idx_q];
    sum     = $signed({{(AE+1){v_q[upd_idx_q][W-1]}}, v_q[upd_idx_q]}) + $signed({upd_acc[ACCW-1], upd_acc});
    if (sum > HI_X)      upd_v = V_HI;
    else if (sum < LO_X) upd_v = V_LO;
    else                 upd_v = sum[W-1:0];
    acc_abs = upd_acc;
    if (upd_acc == ACC_MIN)     acc_abs = ACC_MAXP;
    else if (upd_acc[ACCW-1])   acc_abs = -upd_acc;

    case (state_q)
      S_IDLE: begin
        if (vwr_en) v_d[vwr_addr] = vwr_data;
        if (start) begin
          state_d = S_CLEAR;
          busy_d  = 1'b1;
          conv_d  = 1'b0;
          iter_d  = '0;
        end
      end
      S_CLEAR: begin
        for (int n = 0; n < NN; n++) acc_d[n] = '0;
        max_abs_d = '0;
        req_idx_d = '0;
        upd_idx_d = '0;
        state_d   = S_SWEEP;
      end
      S_SWEEP: begin
        if (hs) begin
          if (req_idx_q == IDX_LAST) state_d = S_DRAIN;
          else                       req_idx_d = req_idx_q + IW'(1);
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        v_d[upd_idx_q] = upd_v;
        if (acc_abs > max_abs_q) max_abs_d = acc_abs;
        if (upd_idx_q == NODE_LAST) state_d = S_CHECK;
        else                        upd_idx_d = upd_idx_q + AW'(1);
      end
      S_CHECK: begin
        iter_d = iter_q + CW'(1);
        if (max_abs_q <= TOL_V || iter_q + CW'(1) == ITER_LIM) begin
          conv_d  = (max_abs_q <= TOL_V);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Registered valid: drops the cycle the window fills or the sweep's last index is taken.
    req_valid_d = (state_d == S_SWEEP) && (outst_d != OUT_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      conv_q      <= 1'b0;
      iter_q      <= '0;
      req_valid_q <= 1'b0;
      req_idx_q   <= '0;
      outst_q     <= '0;
      upd_idx_q   <= '0;
      max_abs_q   <= '0;
      err_q       <= 1'b0;
      for (int n = 0; n < NN; n++) begin
        v_q[n]   <= '0;
        acc_q[n] <= '0;
      end
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      conv_q      <= conv_d;
      iter_q      <= iter_d;
      req_valid_q <= req_valid_d;
      req_idx_q   <= req_idx_d;
      outst_q     <= outst_d;
      upd_idx_q   <= upd_idx_d;
      max_abs_q   <= max_abs_d;
      err_q       <= err_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
    end
  end
endmodule

// File: doc/node_relax_scheduler.md
Name: node_relax_scheduler

Overview:
- Iterative relaxation controller for the switch-level node network.
- Owns the NN-entry node-voltage register file and the per-node current accumulators.
- Time-multiplexes one shared, external transistor/pad current evaluator across NT device indices per sweep.
- Applies accumulated currents to node voltages and repeats sweeps until the network converges or an iteration limit is reached.

Parameters:
W, 16, node voltage / device current width (signed two's complement)
NN, 64, number of nodes
NT, 128, number of devices (transistors, pullups, pads) in the evaluator
AE, 4, accumulator extension bits; accumulator width W+AE
V_HI, 16'sh3FFF, saturation ceiling for node voltages
V_LO, -16'sh4000, saturation floor for node voltages
TOL, 4, convergence threshold on max |accumulated current|
MAX_ITER, 64, iteration limit per start
MAX_OUT, 4, max outstanding evaluator requests

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a relaxation run (sampled only in IDLE)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when a run ends
converged  out  1  valid at done; held until the next start
iter_count  out  clog2(MAX_ITER+1)  number of completed sweeps in the current/last run
vwr_en  in  1  host voltage write; honoured only in IDLE
vwr_addr  in  clog2(NN)  host write node
vwr_data  in  W  host write value (stored unsaturated)
vrd_addr_a  in  clog2(NN)  combinational read port A (for evaluator/host)
vrd_data_a  out  W  voltage of node vrd_addr_a
vrd_addr_b  in  clog2(NN)  combinational read port B
vrd_data_b  out  W  voltage of node vrd_addr_b
req_valid  out  1  evaluate device req_idx
req_ready  in  1  evaluator accepts request
req_idx  out  clog2(NT)  device index
rsp_valid  in  1  evaluator result (no backpressure)
rsp_na  in  clog2(NN)  node receiving +rsp_i
rsp_nb  in  clog2(NN)  node receiving -rsp_i
rsp_nb_en  in  1  0 = single-ended device (vcc/vss/pullup/pad); rsp_nb ignored
rsp_i  in  W  signed current

Behaviour:
- Reset values:
  - State is IDLE.
  - busy=0, done=0, converged=0, iter_count=0, req_valid=0, req_idx=0.
  - All voltages and accumulators are 0; the outstanding count is 0.
- States: IDLE -> CLEAR -> SWEEP -> DRAIN -> UPDATE -> CHECK -> (CLEAR | FINISH) -> IDLE.
- IDLE:
  - start=1 moves to CLEAR and resets iter_count to 0; busy rises next cycle.
  - vwr_en writes vwr_data in the same edge.
  - If vwr_en and start coincide, the write is applied first and the run sees the new value.
- CLEAR: zeroes the accumulators and max_abs, taking 1 cycle.
- SWEEP:
  - Issues req_idx = 0..NT-1 in order; req_idx advances only on req_valid&&req_ready.
  - req_valid is deasserted while outstanding == MAX_OUT.
  - After the handshake for index NT-1, moves to DRAIN.
- Outstanding count:
  - +1 on a handshake, -1 on rsp_valid; both in the same cycle leave it unchanged.
  - rsp_valid with outstanding==0 is ignored and sets an internal sticky error, visible in simulation only.
- Response accumulation (any state with outstanding>0):
  - acc[na] += sext(rsp_i).
  - If rsp_nb_en, acc[nb] -= sext(rsp_i).
  - If na==nb with rsp_nb_en, the net change is 0.
  - Accumulators wrap at W+AE bits and are never saturated.
- DRAIN: waits for outstanding==0, then moves to UPDATE.
- UPDATE:
  - One node per cycle, n = 0..NN-1, taking NN cycles.
  - v[n] = clamp(v[n] + acc[n], V_LO, V_HI), computed at W+AE+1 bits.
  - max_abs = max(max_abs, |acc[n]|), with |most-negative| saturating to the max positive value.
- CHECK (1 cycle): iter_count += 1.
  - If max_abs <= TOL: converged=1, go to FINISH.
  - Else if iter_count+1 == MAX_ITER: converged=0, go to FINISH.
  - Else go to CLEAR.
- FINISH: done=1 for one cycle, busy drops the same cycle, returns to IDLE.
- start is ignored while busy. vwr_en is ignored while busy.
- Read ports are combinational from the register file at all times, and reflect UPDATE writes the cycle after.
- Minimum latency per iteration: 1 + NT + drain + NN + 1 cycles.
- Async reset mid-run aborts immediately to reset values; in-flight responses after reset are dropped.

Test Plan:
- Reset mid-sweep: assert rst_n=0 during SWEEP at req_idx=37 -> all outputs return to reset values asynchronously; v[*]=0; a subsequent start runs from req_idx=0.
- Single sweep converges: NT=4, evaluator returns rsp_i=0 for all, zero latency, ready=1 -> done after 1+4+0+NN+1+1 cycles with converged=1 and iter_count=1.
- Pullup accumulation: node 3 starts at 0; evaluator returns single-ended rsp_i=V_HI>>4 on na=3 until v[3] within TOL of V_HI -> v[3] rises monotonically, never exceeds V_HI, converged=1.
- Two-terminal conservation: rsp_na=1, rsp_nb=2, rsp_i=100, nb_en=1 on one device, others 0 -> after the first UPDATE v[1]=+100 and v[2]=-100; same with na=nb=5 -> v[5] unchanged.
- Backpressure and outstanding: MAX_OUT=4, evaluator holds rsp for 10 cycles, ready toggles every other cycle -> never more than 4 unanswered requests, every index 0..NT-1 issued exactly once per sweep, in order.
- Non-convergence: evaluator always returns rsp_i=TOL+1 on node 0 -> done after exactly MAX_ITER sweeps, converged=0, v[0] saturated at V_HI; start while busy and vwr_en while busy have no effect.
